// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM memory driver and its device-side responder:
// opcodes, FSM state encoding, pending-action type and the default read latency.
package psram_pkg;

  // Opcodes understood by the PSRAM device
  localparam logic [7:0] CMD_RSTEN    = 8'h66;
  localparam logic [7:0] CMD_RST      = 8'h99;
  localparam logic [7:0] SPI2QPI      = 8'h35;
  localparam logic [7:0] CMD_READ     = 8'hEB;
  localparam logic [7:0] CMD_WRITE    = 8'h38;
  localparam logic [7:0] CMD_QPI_EXIT = 8'hF5;

  // Responder FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_WDATA  = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  // Wait cycles between the last address nibble and the first read nibble
  localparam int READ_WAIT_DEF = 6;

  // Action latched by a complete command, applied when chip enable rises
  typedef enum logic [1:0] {
    PEND_NONE    = 2'd0,
    PEND_RST     = 2'd1,
    PEND_QPI_ON  = 2'd2,
    PEND_QPI_OFF = 2'd3
  } pend_e;

  // Nibble idx of a 16-bit word, idx 0 being bits [15:12]
  function automatic logic [3:0] nibble_sel(input logic [15:0] w, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = w[15:12];
      2'd1:    n = w[11:8];
      2'd2:    n = w[7:4];
      default: n = w[3:0];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/psram_word_ram.sv
// Single-port word array with synchronous read and write enable.
// Read returns the old contents on a same-cycle write. No reset on purpose,
// so it maps onto block RAM.
module psram_word_ram
  import psram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [0:(1<<ADDR_W)-1];
  logic [15:0] rdata_q;

  // Synchronous write and registered read of the addressed word
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/psram_responder.sv
// Device-side model of the SPI/QPI PSRAM. Decodes reset, mode-switch and quad
// read/write commands and serves them from an internal 16-bit word array.
// Host drives on negedge; everything here samples and updates on posedge.
// A complete command only latches its mode/reset effect; the effect is applied
// on the edge where mem_ce is seen high, so truncated commands change nothing.
// READ_WAIT must be at least 2 so the array read of the first word has landed
// before its first nibble is registered. ADDR_W must not exceed 24.
module psram_responder
  import psram_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int READ_WAIT = READ_WAIT_DEF
) (
  input  logic       mem_clk,
  input  logic       rst,
  input  logic       mem_ce,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic       sio_oe,
  output logic       qpi_mode,
  output logic       rst_done,
  output logic       cmd_err,
  output logic [2:0] fsm_state_o
);

  localparam logic [7:0] WAIT_LAST = 8'(READ_WAIT - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;       // cycle/nibble count within the phase
  logic [6:0]        cmd_sh_q, cmd_sh_d; // opcode bits received so far
  logic [11:0]       wsh_q, wsh_d;       // first three nibbles of a write word
  logic [ADDR_W-1:0] ptr_q, ptr_d;       // word pointer; address nibbles shift in here
  logic              is_rd_q, is_rd_d;
  pend_e             pend_q, pend_d;
  logic              arm_q, arm_d;       // RSTEN seen on the previous command
  logic              qpi_q, qpi_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              oe_q, oe_d;
  logic [3:0]        out_q, out_d;

  logic [7:0]        cmd_next;
  logic              cmd_last;
  logic [15:0]       word_next;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_rdata;

  assign cmd_next  = qpi_q ? {cmd_sh_q[3:0], sio_in} : {cmd_sh_q, sio_in[0]};
  assign cmd_last  = qpi_q ? (cnt_q == 8'd1) : (cnt_q == 8'd7);
  assign word_next = {wsh_q, sio_in};

  // During the last nibble of a read word, look one word ahead so the next
  // word is ready with no bubble.
  assign ram_addr = ((state_q == ST_RDATA) && (cnt_q[1:0] == 2'd3)) ? ptr_q + ADDR_W'(1) : ptr_q;

  psram_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i   (mem_clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (word_next),
    .rdata_o (ram_rdata)
  );

  // Next-state logic for the transaction FSM and its datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_sh_d = cmd_sh_q;
    wsh_d    = wsh_q;
    ptr_d    = ptr_q;
    is_rd_d  = is_rd_q;
    pend_d   = pend_q;
    arm_d    = arm_q;
    qpi_d    = qpi_q;
    err_d    = err_q;
    done_d   = 1'b0;
    oe_d     = oe_q;
    out_d    = out_q;
    ram_we   = 1'b0;
    if (mem_ce) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      pend_d  = PEND_NONE;
      case (pend_q)
        PEND_RST: begin
          qpi_d  = 1'b0;
          err_d  = 1'b0;
          arm_d  = 1'b0;
          done_d = 1'b1;
        end
        PEND_QPI_ON:  qpi_d = 1'b1;
        PEND_QPI_OFF: qpi_d = 1'b0;
        default: ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_sh_d = cmd_next[6:0];
          cnt_d    = 8'd1;
          state_d  = ST_CMD;
        end
        ST_CMD: begin
          cmd_sh_d = cmd_next[6:0];
          cnt_d    = cnt_q + 8'd1;
          if (cmd_last) begin
            cnt_d   = '0;
            state_d = ST_IGNORE;
            arm_d   = 1'b0;
            case (cmd_next)
              CMD_RSTEN: arm_d = 1'b1;
              CMD_RST: begin
                if (arm_q) pend_d = PEND_RST;
              end
              SPI2QPI: begin
                if (!qpi_q) pend_d = PEND_QPI_ON;
                else        err_d  = 1'b1;
              end
              CMD_QPI_EXIT: begin
                if (qpi_q) pend_d = PEND_QPI_OFF;
                else       err_d  = 1'b1;
              end
              CMD_READ, CMD_WRITE: begin
                if (qpi_q) begin
                  state_d = ST_ADDR;
                  is_rd_d = (cmd_next == CMD_READ);
                end else begin
                  err_d = 1'b1;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        ST_ADDR: begin
          ptr_d = ADDR_W'({ptr_q, sio_in});
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d   = '0;
            state_d = is_rd_q ? ST_WAIT : ST_WDATA;
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == WAIT_LAST) begin
            state_d = ST_RDATA;
            oe_d    = 1'b1;
            out_d   = nibble_sel(ram_rdata, 2'd0);
            cnt_d   = 8'd1;
          end
        end
        ST_RDATA: begin
          out_d = nibble_sel(ram_rdata, cnt_q[1:0]);
          cnt_d = {6'd0, cnt_q[1:0] + 2'd1};
          if (cnt_q[1:0] == 2'd3) ptr_d = ptr_q + ADDR_W'(1);
        end
        ST_WDATA: begin
          wsh_d = word_next[11:0];
          cnt_d = {6'd0, cnt_q[1:0] + 2'd1};
          if (cnt_q[1:0] == 2'd3) begin
            ram_we = 1'b1;
            ptr_d  = ptr_q + ADDR_W'(1);
          end
        end
        default: ; // ST_IGNORE: wait for mem_ce to rise
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cmd_sh_q <= '0;
      wsh_q    <= '0;
      ptr_q    <= '0;
      is_rd_q  <= 1'b0;
      pend_q   <= PEND_NONE;
      arm_q    <= 1'b0;
      qpi_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      oe_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_sh_q <= cmd_sh_d;
      wsh_q    <= wsh_d;
      ptr_q    <= ptr_d;
      is_rd_q  <= is_rd_d;
      pend_q   <= pend_d;
      arm_q    <= arm_d;
      qpi_q    <= qpi_d;
      err_q    <= err_d;
      done_q   <= done_d;
      oe_q     <= oe_d;
      out_q    <= out_d;
    end
  end

  assign sio_out     = out_q;
  assign sio_oe      = oe_q;
  assign qpi_mode    = qpi_q;
  assign rst_done    = done_q;
  assign cmd_err     = err_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_psram_responder.sv
// Bench for psram_responder. The driver acts as the memory host and, for every
// rising edge it drives, queues what the device outputs must be after that edge,
// derived from a plain word-array model and the command rules.
module tb_psram_responder;
  import psram_pkg::*;

  localparam int ADDR_W = 10;
  localparam int RW     = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic       mem_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       mem_ce  = 1'b1;
  logic [3:0] sio_in  = 4'h0;
  logic [3:0] sio_out;
  logic       sio_oe, qpi_mode, rst_done, cmd_err;
  logic [2:0] fsm_state_o;

  always #5 mem_clk = ~mem_clk;

  psram_responder #(.ADDR_W(ADDR_W), .READ_WAIT(RW)) dut (
    .mem_clk     (mem_clk),
    .rst         (rst),
    .mem_ce      (mem_ce),
    .sio_in      (sio_in),
    .sio_out     (sio_out),
    .sio_oe      (sio_oe),
    .qpi_mode    (qpi_mode),
    .rst_done    (rst_done),
    .cmd_err     (cmd_err),
    .fsm_state_o (fsm_state_o)
  );

  // ---------------- model state / scoreboard ----------------
  typedef struct packed {
    logic       oe;
    logic [3:0] nib;
    logic       chk_nib;
    logic       done;
    logic       qpi;
    logic       err;
    logic       chk_idle;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  obs_q[$];
  logic [15:0] mem_m [0:DEPTH-1];
  logic        qpi_m = 1'b0;
  logic        err_m = 1'b0;
  logic        arm_m = 1'b0;
  int          pend_m = 0;   // 0 none, 1 reset, 2 enter QPI, 3 leave QPI
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic        cmp_on = 1'b0;
  exp_t        cmp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e     = '0;
    e.qpi = qpi_m;
    e.err = err_m;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic ce, input logic [3:0] d, input exp_t e);
    @(negedge mem_clk);
    mem_ce = ce;
    sio_in = d;
    exp_q.push_back(e);
  endtask

  task automatic decode_m(input logic [7:0] op);
    logic ok;
    if (!qpi_m) ok = (op == CMD_RSTEN) || (op == CMD_RST) || (op == SPI2QPI);
    else        ok = (op == CMD_RSTEN) || (op == CMD_RST) || (op == CMD_READ) ||
                     (op == CMD_WRITE) || (op == CMD_QPI_EXIT);
    if (!ok) begin
      err_m = 1'b1;
      arm_m = 1'b0;
    end else if (op == CMD_RSTEN) begin
      arm_m = 1'b1;
    end else begin
      if (op == CMD_RST && arm_m) pend_m = 1;
      if (op == SPI2QPI)          pend_m = 2;
      if (op == CMD_QPI_EXIT)     pend_m = 3;
      arm_m = 1'b0;
    end
  endtask

  // nsteps below the full length sends a truncated command
  task automatic command(input logic [7:0] op, input int nsteps);
    int n;
    logic [3:0] d;
    n = qpi_m ? 2 : 8;
    for (int i = 0; i < nsteps; i++) begin
      if (qpi_m) d = (i == 0) ? op[7:4] : op[3:0];
      else       d = {3'b000, op[7-i]};
      if (i == n - 1) decode_m(op);
      step(1'b0, d, idle_e());
    end
  endtask

  task automatic ce_high();
    exp_t e;
    if (pend_m == 1) begin
      qpi_m = 1'b0;
      err_m = 1'b0;
      arm_m = 1'b0;
    end else if (pend_m == 2) begin
      qpi_m = 1'b1;
    end else if (pend_m == 3) begin
      qpi_m = 1'b0;
    end
    e          = idle_e();
    e.done     = (pend_m == 1);
    e.chk_idle = 1'b1;
    pend_m     = 0;
    step(1'b1, 4'h0, e);
    repeat (2) step(1'b1, 4'h0, idle_e());
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 0; i < 6; i++) step(1'b0, a[23-4*i -: 4], idle_e());
  endtask

  task automatic qpi_write(input logic [23:0] a, input logic [15:0] w0, input logic [15:0] w1,
                           input int nnib, input bit close);
    logic [ADDR_W-1:0] p;
    logic [15:0] w;
    command(CMD_WRITE, 2);
    send_addr(a);
    p = a[ADDR_W-1:0];
    for (int t = 0; t < nnib; t++) begin
      w = (t < 4) ? w0 : w1;
      if (t % 4 == 3) begin
        mem_m[p] = w;
        p++;
      end
      step(1'b0, w[15-4*(t%4) -: 4], idle_e());
    end
    if (close) ce_high();
  endtask

  task automatic qpi_read(input logic [23:0] a, input int nwords);
    logic [ADDR_W-1:0] q;
    logic [15:0] w;
    exp_t e;
    command(CMD_READ, 2);
    send_addr(a);
    for (int c = 8; c < 7 + RW; c++) step(1'b0, 4'h0, idle_e());
    for (int t = 0; t < 4 * nwords; t++) begin
      q         = a[ADDR_W-1:0] + ADDR_W'(t / 4);
      w         = mem_m[q];
      e         = idle_e();
      e.oe      = 1'b1;
      e.chk_nib = 1'b1;
      e.nib     = w[15-4*(t%4) -: 4];
      step(1'b0, 4'h0, e);
    end
    ce_high();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      @(posedge mem_clk);
      #2;
      guard++;
    end
    if (guard >= 1000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] obs_word();
    logic [31:0] v;
    v = '0;
    foreach (obs_q[i]) v = {v[27:0], obs_q[i]};
    return v;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(posedge mem_clk);
      #1;
      if (cmp_on) begin
        if (exp_q.size() > 0) cmp_e = exp_q.pop_front();
        else                  cmp_e = idle_e();
        chk("sio_oe",   32'(sio_oe),   32'(cmp_e.oe));
        if (cmp_e.chk_nib)  chk("sio_out", 32'(sio_out), 32'(cmp_e.nib));
        chk("qpi_mode", 32'(qpi_mode), 32'(cmp_e.qpi));
        chk("cmd_err",  32'(cmd_err),  32'(cmp_e.err));
        chk("rst_done", 32'(rst_done), 32'(cmp_e.done));
        if (cmp_e.chk_idle) chk("state_idle", 32'(fsm_state_o), 32'(ST_IDLE));
        if (rst_done) done_cnt++;
        if (sio_oe) obs_q.push_back(sio_out);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge mem_clk);
    chk("rst_sio_oe",   32'(sio_oe),      32'd0);
    chk("rst_sio_out",  32'(sio_out),     32'd0);
    chk("rst_qpi",      32'(qpi_mode),    32'd0);
    chk("rst_done0",    32'(rst_done),    32'd0);
    chk("rst_cmd_err",  32'(cmd_err),     32'd0);
    chk("rst_state",    32'(fsm_state_o), 32'(ST_IDLE));
    rst    = 1'b0;
    cmp_on = 1'b1;
    repeat (2) step(1'b1, 4'h0, idle_e());

    // SPI: unarmed reset, truncated command, bad opcode, armed reset, enter QPI
    command(CMD_RST, 8);   ce_high(); drain();
    chk("unarmed_rst_done", 32'(done_cnt), 32'd0);
    command(8'hAB, 5);     ce_high(); drain();
    chk("short_cmd_err", 32'(cmd_err), 32'd0);
    command(8'hAB, 8);     ce_high(); drain();
    chk("bad_op_err", 32'(cmd_err), 32'd1);
    command(CMD_RSTEN, 8); ce_high();
    command(CMD_RST, 8);   ce_high(); drain();
    chk("sw_rst_done_once", 32'(done_cnt), 32'd1);
    chk("sw_rst_clears_err", 32'(cmd_err), 32'd0);
    command(SPI2QPI, 8);   ce_high(); drain();
    chk("enter_qpi", 32'(qpi_mode), 32'd1);

    // QPI write then read back two words
    qpi_write(24'h000010, 16'hA5C3, 16'h1234, 8, 1'b1);
    drain(); obs_q.delete();
    qpi_read(24'h000010, 2); drain();
    chk("read_nibbles", obs_word(), 32'hA5C31234);
    chk("read_nibble_count", 32'(obs_q.size()), 32'd8);

    // Pointer wrap at the top of the array
    qpi_write(24'h0003FF, 16'hBEEF, 16'hCAFE, 8, 1'b1);
    drain(); obs_q.delete();
    qpi_read(24'h0003FF, 2); drain();
    chk("wrap_read", obs_word(), 32'hBEEFCAFE);
    obs_q.delete();
    qpi_read(24'h000000, 1); drain();
    chk("wrap_word0", obs_word(), 32'h0000CAFE);

    // Partial word discarded when mem_ce rises
    qpi_write(24'h000010, 16'h7777, 16'h0000, 2, 1'b1);
    drain(); obs_q.delete();
    qpi_read(24'h000010, 1); drain();
    chk("partial_discard", obs_word(), 32'h0000A5C3);

    // Hardware reset in the middle of a write
    qpi_write(24'h000011, 16'h9999, 16'h0000, 2, 1'b0);
    drain();
    @(negedge mem_clk);
    rst    = 1'b1;
    mem_ce = 1'b1;
    qpi_m  = 1'b0;
    err_m  = 1'b0;
    arm_m  = 1'b0;
    pend_m = 0;
    #1;
    chk("midrst_state", 32'(fsm_state_o), 32'(ST_IDLE));
    chk("midrst_oe",    32'(sio_oe),      32'd0);
    chk("midrst_qpi",   32'(qpi_mode),    32'd0);
    repeat (2) @(negedge mem_clk);
    rst = 1'b0;
    repeat (2) step(1'b1, 4'h0, idle_e());
    command(SPI2QPI, 8); ce_high();
    drain(); obs_q.delete();
    qpi_read(24'h000011, 1); drain();
    chk("midrst_word_kept", obs_word(), 32'h00001234);

    // Leave QPI and come back
    command(CMD_QPI_EXIT, 2); ce_high(); drain();
    chk("exit_qpi", 32'(qpi_mode), 32'd0);
    command(SPI2QPI, 8); ce_high(); drain();
    chk("reenter_qpi", 32'(qpi_mode), 32'd1);

    repeat (3) @(negedge mem_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
